// File: rtl/rst_seq_ctrl.sv
// Ordered reset release sequencer: brings reset domains out of reset one at a time,
// waiting for each domain's ready (or a timeout) before starting the next delay.
module rst_seq_ctrl #(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DLY   = 16,
    parameter int SW_HOLD     = 8,
    parameter int RDY_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  sw_rst_i,
    input  logic [NUM_STAGES-1:0] rdy_i,
    output logic [NUM_STAGES-1:0] rst_o,
    output logic                  done_o,
    output logic                  timeout_o
);

    localparam int MAX_HS  = (STAGE_DLY > SW_HOLD) ? STAGE_DLY : SW_HOLD;
    localparam int MAX_CNT = (MAX_HS > RDY_TIMEOUT) ? MAX_HS : RDY_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT);
    localparam int IW      = $clog2(NUM_STAGES);

    localparam logic [CW-1:0] STAGE_LOAD = CW'(STAGE_DLY - 1);
    localparam logic [CW-1:0] SW_LOAD    = CW'(SW_HOLD - 1);
    localparam logic [CW-1:0] TO_LOAD    = CW'(RDY_TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        HOLD,
        COUNT,
        WAIT_RDY,
        SWHOLD,
        DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;

    // One shared down-counter serves the release delay, the ready timeout and the
    // software hold; a software request outranks every other event except in HOLD.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= HOLD;
            idx       <= '0;
            cnt       <= '0;
            rst_o     <= '1;
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
        end else if (sw_rst_i && (state != HOLD)) begin
            state  <= SWHOLD;
            cnt    <= SW_LOAD;
            rst_o  <= '1;
            done_o <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    state <= COUNT;
                    idx   <= '0;
                    cnt   <= STAGE_LOAD;
                end
                COUNT: begin
                    if (cnt == '0) begin
                        rst_o[idx] <= 1'b0;
                        state      <= WAIT_RDY;
                        cnt        <= TO_LOAD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WAIT_RDY: begin
                    // A ready arriving on the final count still counts as ready, not a timeout.
                    if (rdy_i[idx] || (cnt == '0)) begin
                        if (!rdy_i[idx]) begin
                            timeout_o <= 1'b1;
                        end
                        if (idx == LAST_IDX) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= COUNT;
                            cnt   <= STAGE_LOAD;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SWHOLD: begin
                    if (cnt == '0) begin
                        state <= COUNT;
                        idx   <= '0;
                        cnt   <= STAGE_LOAD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: hand-derived vector table, corner-case sequences and
// randomized runs checked against an event-timeline model of the release sequence.
module tb_rst_seq_ctrl;

    localparam int NS          = 4;
    localparam int STAGE_DLY   = 16;
    localparam int SW_HOLD     = 8;
    localparam int RDY_TIMEOUT = 256;
    localparam int NEVER       = 100000;
    localparam int NEVER_EDGE  = 1000000000;

    typedef struct packed {
        logic                 isHw;
        logic                 noise;
        logic [31:0]          swLen;
        logic [NS-1:0][31:0]  dly;
        logic [NS-1:0][31:0]  fallAt;
        logic [31:0]          doneAt;
        logic [31:0]          toAt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          sw_rst_i = 1'b0;
    logic [NS-1:0] rdy_i = '0;
    logic [NS-1:0] rst_o;
    logic          done_o;
    logic          timeout_o;

    int   nCompared = 0;
    int   nMismatched = 0;
    bit   sticky = 1'b0;
    vec_t vecs [6];
    vec_t v;
    int   endC;

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .NUM_STAGES (NS),
        .STAGE_DLY  (STAGE_DLY),
        .SW_HOLD    (SW_HOLD),
        .RDY_TIMEOUT(RDY_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_ni   (rst_ni),
        .sw_rst_i (sw_rst_i),
        .rdy_i    (rdy_i),
        .rst_o    (rst_o),
        .done_o   (done_o),
        .timeout_o(timeout_o)
    );

    function automatic vec_t mkVec(input bit isHw, input int swLen, input bit noise,
                                   input int d0, input int d1, input int d2, input int d3,
                                   input int f0, input int f1, input int f2, input int f3,
                                   input int doneAt, input int toAt);
        vec_t r;
        r           = '0;
        r.isHw      = isHw;
        r.noise     = noise;
        r.swLen     = swLen;
        r.dly[0]    = d0;
        r.dly[1]    = d1;
        r.dly[2]    = d2;
        r.dly[3]    = d3;
        r.fallAt[0] = f0;
        r.fallAt[1] = f1;
        r.fallAt[2] = f2;
        r.fallAt[3] = f3;
        r.doneAt    = doneAt;
        r.toAt      = toAt;
        return r;
    endfunction

    // Timeline: each stage falls STAGE_DLY edges after the previous wait ended; a wait
    // lasts until ready is seen or RDY_TIMEOUT edges pass, whichever comes first.
    function automatic vec_t modelTimeline(input vec_t vin, input bit stickyIn);
        vec_t r;
        int   t;
        int   d;
        int   firstTo;
        r       = vin;
        firstTo = NEVER_EDGE;
        t       = vin.isHw ? 1 : int'(vin.swLen) - 1 + SW_HOLD;
        for (int k = 0; k < NS; k++) begin
            t           = t + STAGE_DLY;
            r.fallAt[k] = t;
            d           = int'(vin.dly[k]);
            if (d > RDY_TIMEOUT) begin
                t = t + RDY_TIMEOUT;
                if (firstTo == NEVER_EDGE) firstTo = t;
            end else begin
                t = t + d;
            end
        end
        r.doneAt = t;
        r.toAt   = (!vin.isHw && stickyIn) ? 0 : firstTo;
        return r;
    endfunction

    function automatic vec_t randomVec(input bit isHw, input int swLen);
        vec_t r;
        int   pick;
        r       = '0;
        r.isHw  = isHw;
        r.swLen = swLen;
        r.noise = 1'($urandom_range(0, 1));
        for (int k = 0; k < NS; k++) begin
            pick = int'($urandom_range(0, 9));
            if (pick < 7)       r.dly[k] = $urandom_range(1, 8);
            else if (pick == 7) r.dly[k] = $urandom_range(250, 256);
            else                r.dly[k] = NEVER;
        end
        return r;
    endfunction

    function automatic logic [NS+1:0] expAt(input vec_t ve, input int c);
        logic [NS+1:0] e;
        for (int k = 0; k < NS; k++) e[k+2] = (c < int'(ve.fallAt[k]));
        e[1] = (c >= int'(ve.doneAt));
        e[0] = (c >= int'(ve.toAt));
        return e;
    endfunction

    task automatic checkOutput(input string name, input int c, input logic [NS+1:0] exp);
        logic [NS+1:0] act;
        act = {rst_o, done_o, timeout_o};
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s cycle=%0d got {rst,done,to}=%b expected=%b", name, c, act, exp);
        end
    endtask

    // Inputs driven after edge c are the ones the DUT samples on edge c+1.
    task automatic applyStimulus(input vec_t ve, input int c);
        int target;
        int fall;
        sw_rst_i = !ve.isHw && (c + 1 < int'(ve.swLen));
        for (int k = 0; k < NS; k++) begin
            fall   = int'(ve.fallAt[k]);
            target = fall + int'(ve.dly[k]);
            if (c + 1 >= target)                  rdy_i[k] = 1'b1;
            else if (ve.noise && c + 1 <= fall)   rdy_i[k] = (((c + k) % 2) == 0);
            else                                  rdy_i[k] = 1'b0;
        end
    endtask

    task automatic runSequence(input vec_t ve, input int stopAt, input string label,
                               output int lastSeen);
        int c;
        int lastC;
        lastC = int'(ve.doneAt) + 3;
        if (ve.isHw) begin
            @(negedge clk);
            rst_ni   = 1'b0;
            sw_rst_i = 1'b0;
            rdy_i    = '0;
            #1;
            checkOutput({label, "/reset"}, -1, {{NS{1'b1}}, 2'b00});
            @(negedge clk);
            rst_ni = 1'b1;
            c      = 0;
            applyStimulus(ve, 0);
        end else begin
            sw_rst_i = 1'b1;
            rdy_i    = '0;
            c        = -1;
        end
        lastSeen = c;
        while (c < lastC) begin
            @(posedge clk);
            c++;
            #1;
            checkOutput(label, c, expAt(ve, c));
            lastSeen = c;
            if (c == stopAt) break;
            applyStimulus(ve, c);
        end
    endtask

    initial begin
        vecs[0] = mkVec(1, 0,  0, 3, 3, 3, 3,          17, 36, 55, 74,   77, NEVER_EDGE);
        vecs[1] = mkVec(1, 0,  0, 3, NEVER, 3, 3,      17, 36, 308, 327, 330, 292);
        vecs[2] = mkVec(0, 1,  0, 1, 1, 1, 1,          24, 41, 58, 75,   76, 0);
        vecs[3] = mkVec(0, 20, 0, 5, 2, 7, 1,          43, 64, 82, 105,  106, 0);
        vecs[4] = mkVec(1, 0,  1, 256, 1, 1, 1,        17, 289, 306, 323, 324, NEVER_EDGE);
        vecs[5] = mkVec(1, 0,  0, 1, 1, 1, NEVER,      17, 34, 51, 68,   324, 324);

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) begin
            runSequence(vecs[i], -1, $sformatf("vec%0d", i), endC);
            sticky = (endC >= int'(vecs[i].toAt));
        end

        $display("[TB] async reset while stage 2 is counting");
        v = mkVec(1, 0, 0, 2, NEVER, 2, 2, 17, 35, 307, 325, 327, 291);
        runSequence(v, 300, "asyncMid", endC);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("asyncMidForced", endC, {{NS{1'b1}}, 2'b00});
        sticky = 1'b0;
        v = modelTimeline(randomVec(1, 0), sticky);
        runSequence(v, -1, "afterAsync", endC);
        sticky = (endC >= int'(v.toAt));

        $display("[TB] software request on the release edge");
        v = mkVec(1, 0, 0, 1, 1, 1, 1, 17, 34, 51, 68, 69, NEVER_EDGE);
        runSequence(v, 33, "swOnRelease", endC);
        sticky = 1'b0;
        v = modelTimeline(randomVec(0, 1), sticky);
        runSequence(v, -1, "swAfterRelease", endC);
        sticky = (endC >= int'(v.toAt));

        $display("[TB] randomized runs");
        for (int r = 0; r < 6; r++) begin
            v = modelTimeline(randomVec(1'($urandom_range(0, 1)), int'($urandom_range(1, 25))), sticky);
            runSequence(v, -1, $sformatf("rand%0d", r), endC);
            sticky = (endC >= int'(v.toAt));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 4, number of ordered reset domains (legal range 2..8).
REQ-002 The block SHALL have parameter STAGE_DLY, default 16, cycles between the ready event of one stage and release of the next (legal range 2..255).
REQ-003 The block SHALL have parameter SW_HOLD, default 8, minimum cycles all resets stay asserted after a software request (legal range 1..255).
REQ-004 The block SHALL have parameter RDY_TIMEOUT, default 256, cycles to wait for a stage ready before forcing progress (legal range 2..4096).
REQ-005 The block SHALL have port clk, input, 1, sole clock; all logic SHALL be clocked on its rising edge.
REQ-006 The block SHALL have port rst_ni, input, 1, asynchronous active-low reset, driven by the upstream reset synchronizer, with deassertion synchronous to clk.
REQ-007 The block SHALL have port sw_rst_i, input, 1, synchronous software reset request, active-high, level-sensitive.
REQ-008 The block SHALL have port rdy_i, input, NUM_STAGES, per-stage "out of reset and ready" indication from each domain, synchronous to clk.
REQ-009 The block SHALL have port rst_o, output, NUM_STAGES, per-stage active-high reset, registered.
REQ-010 The block SHALL have port done_o, output, 1, high when every stage is released and accepted.
REQ-011 The block SHALL have port timeout_o, output, 1, sticky flag set when any ready wait timed out.

Function
REQ-012 The block SHALL implement FSM states HOLD, COUNT, WAIT_RDY, SWHOLD and DONE, with a stage index idx of width $clog2(NUM_STAGES) and a single shared down-counter wide enough for max(STAGE_DLY, SW_HOLD, RDY_TIMEOUT).
REQ-013 In HOLD, the first rising edge with rst_ni high SHALL move the FSM to COUNT with idx=0 and counter=STAGE_DLY-1.
REQ-014 In COUNT, the counter SHALL decrement each cycle; at counter==0 the next edge SHALL clear rst_o[idx] and move the FSM to WAIT_RDY with counter=RDY_TIMEOUT-1.
REQ-015 rst_o[0] SHALL therefore fall exactly on the STAGE_DLY-th rising edge after the first edge with rst_ni high.
REQ-016 In WAIT_RDY, rdy_i[idx] high SHALL end the wait on that edge: if idx<NUM_STAGES-1, idx increments and the FSM returns to COUNT with counter=STAGE_DLY-1; otherwise the FSM goes to DONE.
REQ-017 In WAIT_RDY, counter==0 with rdy_i[idx] low SHALL set timeout_o and advance exactly as if the ready had arrived.
REQ-018 rdy_i bits of stages whose rst_o is still asserted SHALL be ignored, and rdy_i SHALL be sampled only in WAIT_RDY.
REQ-019 Released stages SHALL stay released: once cleared, an rst_o bit SHALL be re-asserted only by rst_ni or by sw_rst_i.
REQ-020 In DONE, done_o SHALL be 1, all rst_o SHALL be 0, and the FSM SHALL stay in DONE until a software or hardware reset.
REQ-021 sw_rst_i sampled high in COUNT, WAIT_RDY or DONE SHALL, on the next edge, set all rst_o to 1, clear done_o, and enter SWHOLD with counter=SW_HOLD-1.
REQ-022 sw_rst_i SHALL take priority over any same-cycle release, ready or timeout event.
REQ-023 In SWHOLD, sw_rst_i high SHALL reload counter to SW_HOLD-1.
REQ-024 In SWHOLD, counter==0 with sw_rst_i low SHALL enter COUNT with idx=0 and counter=STAGE_DLY-1.
REQ-025 sw_rst_i SHALL be ignored in HOLD.
REQ-026 timeout_o SHALL NOT be cleared by sw_rst_i.
REQ-027 Stages SHALL release strictly in ascending index order, with at most one rst_o bit changing from 1 to 0 per cycle.

Reset
REQ-028 rst_ni low SHALL immediately and asynchronously force state=HOLD, idx=0, counter=0, rst_o=all ones, done_o=0 and timeout_o=0, irrespective of clk and of the current state, including mid-sequence.
REQ-029 All outputs SHALL be glitch-free register outputs; no output SHALL depend combinationally on any input other than via the asynchronous reset.

Verification
REQ-030 Nominal release: defaults, rdy_i[k] driven 3 cycles after rst_o[k] falls -> rst_o walks 4'b1111, 1110, 1100, 1000, 0000; rst_o[0] falls at edge 16 and each later stage falls 19 edges after the previous; done_o=1 on the edge after rdy_i[3] is seen; timeout_o=0.
REQ-031 Timeout: rdy_i[1] tied low -> rst_o[1] still releases; rst_o[2] releases STAGE_DLY+RDY_TIMEOUT cycles after rst_o[1] falls; timeout_o=1; done_o is reached; timeout_o stays 1 after a later sw_rst_i.
REQ-032 Software reset in DONE: 1-cycle sw_rst_i pulse -> rst_o=4'b1111 and done_o=0 next edge; rst_o[0] falls SW_HOLD+STAGE_DLY edges after the pulse edge; held sw_rst_i of 20 cycles extends the hold accordingly.
REQ-033 Async reset mid-sequence: rst_ni pulled low between clk edges while idx=2 -> rst_o=4'b1111 and done_o=0 before the next clk edge; a fresh sequence starts from stage 0 after release.
REQ-034 Simultaneous events: sw_rst_i high on the same edge that counter==0 in COUNT -> no stage is released and SWHOLD is entered; rdy_i[3] asserted early while rst_o[3]=1 -> ignored, and no premature done_o.
